// File: rtl/uart_rx_pkg.sv
// Purpose: shared receive-frame state encoding and default bit divisor for the UART pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_pkg;

    // Core clock cycles per serial bit: 25 MHz / 115200 baud.
    localparam int unsigned UART_DIVISOR = 217;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Purpose: generic two-flop synchroniser for a single asynchronous input, set to 1 on reset.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; both stages preset high so an idle-high line looks idle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver; deserialises RX into bytes, flags framing errors and overruns.
// Latency: VALID rises 2 + DIVISOR/2 + 9*DIVISOR + 1 cycles after the RX start-bit falling edge.
// Backpressure: none on the line; an unacknowledged byte is overwritten by the next (OVR set).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIVISOR = UART_DIVISOR
) (
    input  logic       CLK,
    input  logic       RST_,
    input  logic       RX,
    input  logic       ACK,
    output logic [7:0] OUT,
    output logic       VALID,
    output logic       OVR,
    output logic       FERR
);

    localparam int unsigned CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIVISOR - 1);

    logic rx_s;

    rx_state_e     state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    bit_q,     bit_d;
    logic [7:0]    shreg_q,   shreg_d;
    logic [7:0]    out_q,     out_d;
    logic          valid_q,   valid_d;
    logic          ovr_q,     ovr_d;
    logic          ferr_q,    ferr_d;
    logic [1:0]    primed_q,  primed_d;
    logic          line_hi_q, line_hi_d;
    logic          tick;

    sync2 u_sync_rx (
        .clk   (CLK),
        .rst_n (RST_),
        .d     (RX),
        .q     (rx_s)
    );

    assign tick = (cnt_q == '0);

    // Next-state: bit timing, frame FSM, byte delivery and consumer handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - CW'(1);
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        out_d     = out_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        ferr_d    = 1'b0;
        // rx_s only carries a real line sample once both synchroniser stages
        // have refilled after reset; until then its preset 1 is not evidence
        // that the line is idle.
        primed_d  = {primed_q[0], 1'b1};
        line_hi_d = line_hi_q | (primed_q[1] & rx_s);

        if (valid_q && ACK) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    if (line_hi_q) begin
                        state_d = ST_START;
                        cnt_d   = HALF_M1;
                    end else begin
                        // Line low since reset: wait for idle rather than framing garbage.
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        cnt_d   = FULL_M1;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    cnt_d   = FULL_M1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        out_d   = shreg_q;
                        valid_d = 1'b1;
                        if (valid_q && !ACK) begin
                            ovr_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset returns everything to idle immediately.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shreg_q   <= 8'h00;
            out_q     <= 8'h00;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            primed_q  <= 2'b00;
            line_hi_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            primed_q  <= primed_d;
            line_hi_q <= line_hi_d;
        end
    end

    assign OUT   = out_q;
    assign VALID = valid_q;
    assign OVR   = ovr_q;
    assign FERR  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx, ack;
    logic [7:0] out_b;
    logic       valid, ovr, ferr;
    logic       rx2, ack2;
    logic [7:0] out2;
    logic       valid2, ovr2, ferr2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx #(.DIVISOR(4)) u_dut (
        .CLK(clk), .RST_(rst_n), .RX(rx), .ACK(ack),
        .OUT(out_b), .VALID(valid), .OVR(ovr), .FERR(ferr)
    );

    uart_rx #(.DIVISOR(217)) u_dut217 (
        .CLK(clk), .RST_(rst_n), .RX(rx2), .ACK(ack2),
        .OUT(out2), .VALID(valid2), .OVR(ovr2), .FERR(ferr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int sel, input logic v);
        if (sel == 0) begin
            rx = v;
            repeat (4) @(posedge clk);
        end else begin
            rx2 = v;
            repeat (217) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] b, input logic stop);
        send_bit(sel, 1'b0);
        for (int k = 0; k < 8; k++) send_bit(sel, b[k]);
        send_bit(sel, stop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [3];
        int         w;
        int         ferr_cnt;
        logic       seen_v;

        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C;
        rst_n = 1'b0; rx = 1'b0; ack = 1'b0; rx2 = 1'b1; ack2 = 1'b0;

        // Reset with RX held low.
        step(3);
        chk("rst_valid", valid, 0);
        chk("rst_out", out_b, 8'h00);
        chk("rst_ovr", ovr, 0);
        chk("rst_ferr", ferr, 0);
        rst_n = 1'b1;
        seen_v = 1'b0; ferr_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            seen_v = seen_v | valid;
            ferr_cnt += int'(ferr);
        end
        chk("low_after_rst_valid", seen_v, 0);
        chk("low_after_rst_ferr", ferr_cnt, 0);
        rx = 1'b1;
        step(5);
        send_frame(0, 8'h55, 1'b1);
        step(1);
        chk("first_valid", valid, 1);
        chk("first_out", out_b, 8'h55);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("first_ack_clear", valid, 0);

        // Single byte with exact latency: VALID first seen after edge 41 from the fall.
        step(3);
        send_frame(0, 8'hA5, 1'b1);
        chk("a5_not_early", valid, 0);
        step(1);
        chk("a5_latency", valid, 1);
        chk("a5_out", out_b, 8'hA5);
        chk("a5_ferr", ferr, 0);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("a5_ack_clear", valid, 0);

        // Back-to-back frames, each acknowledged promptly.
        step(3);
        fork
            begin
                send_frame(0, 8'h00, 1'b1);
                send_frame(0, 8'hFF, 1'b1);
                send_frame(0, 8'h3C, 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    w = 0;
                    while (!valid && w < 100) begin step(1); w++; end
                    chk("b2b_wait", w < 100, 1);
                    chk("b2b_out", out_b, b2b[i]);
                    chk("b2b_ovr", ovr, 0);
                    ack = 1'b1; step(1); ack = 1'b0;
                end
            end
        join
        step(3);
        chk("b2b_end_ovr", ovr, 0);
        chk("b2b_end_valid", valid, 0);

        // Back-to-back at the full-rate divisor.
        fork
            begin
                send_frame(1, 8'h41, 1'b1);
                send_frame(1, 8'h41, 1'b1);
            end
            begin
                for (int i = 0; i < 2; i++) begin
                    w = 0;
                    while (!valid2 && w < 3000) begin step(1); w++; end
                    chk("d217_wait", w < 3000, 1);
                    chk("d217_out", out2, 8'h41);
                    chk("d217_ovr", ovr2, 0);
                    ack2 = 1'b1; step(1); ack2 = 1'b0;
                end
            end
        join
        step(250);
        chk("d217_ferr", ferr2, 0);

        // Overrun: newest byte wins and OVR sticks until ACK.
        send_frame(0, 8'h11, 1'b1);
        send_frame(0, 8'h22, 1'b1);
        step(2);
        chk("ovr_valid", valid, 1);
        chk("ovr_out", out_b, 8'h22);
        chk("ovr_flag", ovr, 1);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("ovr_ack_valid", valid, 0);
        chk("ovr_ack_flag", ovr, 0);

        // Delivery in the same cycle as ACK of the previous byte.
        step(2);
        send_frame(0, 8'h33, 1'b1);
        step(2);
        chk("coin_first_valid", valid, 1);
        send_frame(0, 8'h44, 1'b1);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("coin_valid", valid, 1);
        chk("coin_out", out_b, 8'h44);
        chk("coin_ovr", ovr, 0);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("coin_clear", valid, 0);

        // Framing error followed by a held-low line.
        step(3);
        send_frame(0, 8'h7E, 1'b0);
        ferr_cnt = 0; seen_v = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            ferr_cnt += int'(ferr);
            seen_v = seen_v | valid;
        end
        chk("ferr_count", ferr_cnt, 1);
        chk("ferr_no_valid", seen_v, 0);
        rx = 1'b1;
        step(5);
        send_frame(0, 8'h42, 1'b1);
        step(2);
        chk("after_ferr_valid", valid, 1);
        chk("after_ferr_out", out_b, 8'h42);

        // Short glitch leaves the pending byte untouched.
        rx = 1'b0; step(1); rx = 1'b1;
        step(20);
        chk("glitch_out", out_b, 8'h42);
        chk("glitch_valid", valid, 1);
        chk("glitch_ovr", ovr, 0);
        chk("glitch_ferr", ferr, 0);

        // Reset in the middle of a frame, then a clean frame.
        send_bit(0, 1'b0);
        for (int k = 0; k < 4; k++) send_bit(0, (8'h99 >> k) & 8'h01);
        rx = 1'b1;
        step(2);
        rst_n = 1'b0;
        step(1);
        chk("midrst_valid", valid, 0);
        chk("midrst_out", out_b, 8'h00);
        chk("midrst_ovr", ovr, 0);
        rst_n = 1'b1;
        step(10);
        chk("midrst_idle", valid, 0);
        send_frame(0, 8'h5A, 1'b1);
        step(2);
        chk("post_rst_valid", valid, 1);
        chk("post_rst_out", out_b, 8'h5A);
        chk("post_rst_ovr", ovr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
